wb_bootcopy16: RTL
==================

// Module: wb_bootcopy16
// PURPOSE
//  Wishbone initiator that copies a boot image, 16 bits at a time, from a
//  16-bit Wishbone responder (boot ROM) to a destination region (RAM). Runs
//  once after reset or on request, then reports done/error. SoC logic holds
//  the CPU in reset while busy_o is high, then releases it.
// PARAMETERS
//  SRC_BASE    32'h0000_0000  byte address of the first source halfword (even)
//  DST_BASE    32'h0000_0000  byte address of the first destination halfword (even)
//  LENGTH      8192           bytes to copy; even, 0..65534
//  TIMEOUT     255            cycles to wait for wb_ack_i before aborting; >=1
//  AUTO_START  1              1: copy starts on the first cycle after reset
//  TGA         1'b0           constant driven on wb_tga_o
// PORTS
//  clk_i     in   1   system clock; everything runs on its rising edge
//  rst_i     in   1   synchronous reset, active high
//  start_i   in   1   pulse: start a copy (honoured in IDLE, DONE, ERR)
//  wb_dat_i  in   16  read data; src byte at adr in [15:8], adr+1 in [7:0]
//  wb_dat_o  out  16  write data
//  wb_adr_o  out  32  byte address; always even
//  wb_we_o   out  1   1 = write cycle
//  wb_tga_o  out  1   address tag, = TGA
//  wb_stb_o  out  1   strobe
//  wb_cyc_o  out  1   bus cycle
//  wb_sel_o  out  2   byte lanes; always 2'b11 while stb is high
//  wb_ack_i  in   1   responder ack; may be combinational from stb&cyc
//  busy_o    out  1   copy in progress
//  done_o    out  1   last copy completed (sticky)
//  err_o     out  1   last copy aborted on timeout (sticky)
// BEHAVIOUR
//  - One clock (clk_i); reset is synchronous and active-high (rst_i).
//  - Reset: state IDLE; cyc/stb/we/busy/done/err = 0; adr = 0; dat_o = 0;
//    sel = 0; offset = 0; timer = 0. Reset mid-copy drops cyc/stb at that
//    edge; the partial copy is not resumed.
//  - All outputs are registered.
//  - States: IDLE, READ, WRITE, DONE, ERR.
//  - Entry: IDLE takes start_i or AUTO_START (first cycle after reset only).
//    DONE and ERR take start_i only. On entry: offset = 0, done = err = 0,
//    busy = 1. LENGTH == 0 goes straight to DONE.
//  - READ: cyc = stb = 1, we = 0, adr = SRC_BASE + offset, sel = 2'b11.
//    On ack: latch wb_dat_i into dat_o and go to WRITE.
//  - WRITE: cyc = stb = 1, we = 1, adr = DST_BASE + offset, dat_o = latched
//    data. On ack: offset += 2. If the new offset == LENGTH, go to DONE;
//    otherwise go to READ.
//  - With a combinational ack, cyc/stb stay high across READ/WRITE, one
//    transfer per cycle. A full copy is LENGTH bus cycles. done_o rises on
//    the edge after the final write ack.
//  - Timer: cleared on entry to READ or WRITE and on every ack; increments
//    each cycle stb is high without ack. When it reaches TIMEOUT: go to ERR,
//    err = 1, busy = 0, and drop cyc/stb on that edge.
//  - DONE: busy = 0, done = 1, cyc = stb = 0. Outputs hold until start_i or
//    rst_i.
//  - Width and wrap: offset is 16 bits. Address sums are 32-bit and wrap
//    modulo 2^32. wb_dat_i is ignored outside READ.
//  - start_i while busy is ignored. start_i in the same cycle as rst_i:
//    reset wins. An ack in the same cycle the timer reaches TIMEOUT counts
//    as a valid ack, not a timeout.
// TESTING
//  - ROM model with comb ack, SRC=0, DST=32'h1000, LENGTH=8 -> 8 bus cycles
//    (adr 0,1000,2,1002,...); RAM[0x1000..7] == ROM[0..7]; done_o=1, busy_o=0.
//  - ROM byte0=8'hAB, byte1=8'hCD -> first write dat_o=16'hABCD, sel=2'b11.
//  - Responder inserts 3 wait states per access, LENGTH=4 -> stb held until
//    ack, no duplicate writes, done after 4 transfers.
//  - Responder never acks, TIMEOUT=5 -> cyc/stb drop after 5 stalled cycles
//    in READ; err_o=1, done_o=0; a later start_i retries from offset 0.
//  - rst_i asserted mid-copy at offset 4 -> next cycle cyc/stb/busy=0; with
//    AUTO_START=1 the copy restarts from SRC_BASE.
//  - LENGTH=0 -> no bus cycle; done_o=1 one cycle after start.

Source files
------------

// File: rtl/wb_bootcopy16_if.sv
// Wishbone bus bundle between the boot-copy initiator and its responder.
// Signal names keep the Wishbone initiator's view (_o leaves the initiator).
interface wb_bootcopy16_if;
  logic [15:0] wb_dat_i;
  logic [15:0] wb_dat_o;
  logic [31:0] wb_adr_o;
  logic        wb_we_o;
  logic        wb_tga_o;
  logic        wb_stb_o;
  logic        wb_cyc_o;
  logic [1:0]  wb_sel_o;
  logic        wb_ack_i;

  modport master (
    input  wb_dat_i, wb_ack_i,
    output wb_dat_o, wb_adr_o, wb_we_o, wb_tga_o, wb_stb_o, wb_cyc_o, wb_sel_o
  );

  modport slave (
    output wb_dat_i, wb_ack_i,
    input  wb_dat_o, wb_adr_o, wb_we_o, wb_tga_o, wb_stb_o, wb_cyc_o, wb_sel_o
  );
endinterface

// File: rtl/wb_bootcopy16.sv
// Boot image copier: reads halfwords from a 16-bit Wishbone ROM and writes
// them to RAM, one read followed by one write per halfword. Every bus output
// and status flag is a register; the comb block only computes next values.
module wb_bootcopy16 #(
  parameter logic [31:0] SRC_BASE   = 32'h0000_0000,
  parameter logic [31:0] DST_BASE   = 32'h0000_0000,
  parameter int          LENGTH     = 8192,
  parameter int          TIMEOUT    = 255,
  parameter bit          AUTO_START = 1'b1,
  parameter logic        TGA        = 1'b0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  wb_bootcopy16_if.master   wb,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

  localparam int          TW  = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO = TW'(TIMEOUT);
  localparam logic [15:0] LEN = 16'(LENGTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_t;

  state_t        state_q, state_d;
  logic [15:0]   offset_q, offset_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [31:0]   adr_q, adr_d;
  logic [15:0]   dat_q, dat_d;
  logic          we_q, we_d;
  logic          cyc_q, cyc_d;
  logic          stb_q, stb_d;
  logic [1:0]    sel_q, sel_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  // One-shot auto-start request: armed by reset, consumed by the first cycle.
  logic          auto_q, auto_d;

  logic          go;
  logic [15:0]   offset_nx;
  logic [TW-1:0] timer_inc;

  // Register every piece of state; reset returns to a quiet bus in IDLE.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      offset_q <= '0;
      timer_q  <= '0;
      adr_q    <= '0;
      dat_q    <= '0;
      we_q     <= 1'b0;
      cyc_q    <= 1'b0;
      stb_q    <= 1'b0;
      sel_q    <= 2'b00;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      auto_q   <= AUTO_START;
    end else begin
      state_q  <= state_d;
      offset_q <= offset_d;
      timer_q  <= timer_d;
      adr_q    <= adr_d;
      dat_q    <= dat_d;
      we_q     <= we_d;
      cyc_q    <= cyc_d;
      stb_q    <= stb_d;
      sel_q    <= sel_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      auto_q   <= auto_d;
    end
  end

  // Next-state and next-output computation for the copy sequencer.
  always_comb begin
    state_d   = state_q;
    offset_d  = offset_q;
    timer_d   = timer_q;
    adr_d     = adr_q;
    dat_d     = dat_q;
    we_d      = we_q;
    cyc_d     = cyc_q;
    stb_d     = stb_q;
    sel_d     = sel_q;
    busy_d    = busy_q;
    done_d    = done_q;
    err_d     = err_q;
    auto_d    = 1'b0;
    go        = 1'b0;
    offset_nx = offset_q + 16'd2;
    timer_inc = timer_q + TW'(1);

    case (state_q)
      S_IDLE: go = start_i | auto_q;

      S_DONE, S_ERR: go = start_i;

      S_READ: begin
        if (wb.wb_ack_i) begin
          // Hold the fetched halfword on dat_o; it is the write data next.
          dat_d   = wb.wb_dat_i;
          state_d = S_WRITE;
          we_d    = 1'b1;
          adr_d   = DST_BASE + {16'h0000, offset_q};
          timer_d = '0;
        end else if (timer_inc == TMO) begin
          state_d = S_ERR;
          timer_d = timer_inc;
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
          we_d    = 1'b0;
          sel_d   = 2'b00;
          busy_d  = 1'b0;
          err_d   = 1'b1;
        end else begin
          timer_d = timer_inc;
        end
      end

      S_WRITE: begin
        if (wb.wb_ack_i) begin
          offset_d = offset_nx;
          timer_d  = '0;
          if (offset_nx == LEN) begin
            state_d = S_DONE;
            cyc_d   = 1'b0;
            stb_d   = 1'b0;
            we_d    = 1'b0;
            sel_d   = 2'b00;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            // Keep cyc/stb up so a zero-wait responder sees one beat per clock.
            state_d = S_READ;
            we_d    = 1'b0;
            adr_d   = SRC_BASE + {16'h0000, offset_nx};
          end
        end else if (timer_inc == TMO) begin
          state_d = S_ERR;
          timer_d = timer_inc;
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
          we_d    = 1'b0;
          sel_d   = 2'b00;
          busy_d  = 1'b0;
          err_d   = 1'b1;
        end else begin
          timer_d = timer_inc;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Common entry into a fresh copy from IDLE, DONE or ERR.
    if (go) begin
      offset_d = '0;
      timer_d  = '0;
      done_d   = 1'b0;
      err_d    = 1'b0;
      if (LEN == 16'd0) begin
        // Nothing to move: report completion without touching the bus.
        state_d = S_DONE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end else begin
        state_d = S_READ;
        busy_d  = 1'b1;
        cyc_d   = 1'b1;
        stb_d   = 1'b1;
        we_d    = 1'b0;
        sel_d   = 2'b11;
        adr_d   = SRC_BASE;
      end
    end
  end

  assign wb.wb_dat_o = dat_q;
  assign wb.wb_adr_o = adr_q;
  assign wb.wb_we_o  = we_q;
  assign wb.wb_tga_o = TGA;
  assign wb.wb_stb_o = stb_q;
  assign wb.wb_cyc_o = cyc_q;
  assign wb.wb_sel_o = sel_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign err_o       = err_q;

endmodule
